// File: rtl/sck_burst_gen.sv
// SCK burst generator: emits num serial-clock pulses of period max(div,3)+1,
// with launch/sample request strobes for the selected CPOL/CPHA mode.
module sck_burst_gen #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8,
  parameter int DLY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] div,
  input  logic [NUM_W-1:0] num,
  input  logic             cpol,
  input  logic             cpha,
  output logic             busy,
  output logic             done,
  output logic             launch_req,
  output logic             sample_req,
  output logic             sck_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;

  // Periods shorter than 4 cycles leave no room for distinct quarter points.
  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(3)) ? CNT_W'(3) : d;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] ph;
  logic [NUM_W-1:0] pc;
  logic [CNT_W-1:0] div_l;
  logic [NUM_W-1:0] num_l;
  logic             cpol_l;
  logic             cpha_l;
  logic [DLY:0]     sck_pipe;

  logic [CNT_W-1:0] p;
  logic [CNT_W:0]   per, q, h, qh, ph_x;
  logic             run, accept, at_end, last, in_win;
  logic             launch_m, sample_m, cpol_nx;

  always_comb begin
    p        = eff_div(div_l);
    per      = {1'b0, p} + 1'b1;
    q        = per >> 2;
    h        = per >> 1;
    qh       = q + h;
    ph_x     = {1'b0, ph};
    run      = (state == S_RUN);
    accept   = (state == S_IDLE) && start;
    at_end   = (ph == p);
    last     = at_end && (pc == num_l - 1'b1);
    in_win   = (ph_x >= q) && (ph_x < qh);
    launch_m = run && !abort && (cpha_l ? (ph_x == q) : (ph == '0));
    sample_m = run && !abort && (cpha_l ? (ph_x == qh) : (ph_x == q));
    cpol_nx  = accept ? cpol : cpol_l;
  end

  // Control state, strobes and the SCK register chain (stage 0 is sck_i).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ph         <= '0;
      pc         <= '0;
      cpol_l     <= 1'b0;
      done       <= 1'b0;
      launch_req <= 1'b0;
      sample_req <= 1'b0;
      sck_pipe   <= '0;
    end else begin
      done       <= (state == S_END);
      launch_req <= launch_m;
      sample_req <= sample_m;
      cpol_l     <= cpol_nx;
      sck_pipe   <= {sck_pipe[DLY-1:0], cpol_nx ^ (run && in_win)};
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= (num == '0) ? S_END : S_RUN;
            ph    <= '0;
            pc    <= '0;
          end
        end
        S_RUN: begin
          if (abort || last) begin
            state <= S_END;
          end else if (at_end) begin
            ph <= '0;
            pc <= pc + 1'b1;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        S_END:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Burst parameters are captured on accept and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      div_l  <= div;
      num_l  <= num;
      cpha_l <= cpha;
    end
  end

  assign busy  = (state != S_IDLE);
  assign sck_o = sck_pipe[DLY];

endmodule

// File: tb/tb_sck_burst_gen.sv
// Bench for sck_burst_gen: directed and random bursts compared cycle by cycle
// against an event-time model derived from period, quarter and pulse counts.
module tb_sck_burst_gen;

  localparam int CNT_W = 8;
  localparam int NUM_W = 8;
  localparam int DLY   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] div;
  logic [NUM_W-1:0] num;
  logic             cpol;
  logic             cpha;
  logic             busy, done, launch_req, sample_req, sck_o;

  int   vectors     = 0;
  int   miscompares = 0;
  logic prev_cpol;

  always #5 clk = ~clk;

  sck_burst_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W), .DLY(DLY)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .div(div), .num(num),
    .cpol(cpol), .cpha(cpha), .busy(busy), .done(done),
    .launch_req(launch_req), .sample_req(sample_req), .sck_o(sck_o)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int j, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, j, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int phase(input int k, input int per);
    return (k - 1) % per;
  endfunction

  function automatic logic run_at(input int k, input int len);
    return (k >= 1) && (k <= len);
  endfunction

  // Entered and left at posedge+1. stop_after>0 ends the check loop early
  // (start left as is) so a reset can be injected mid-burst.
  task automatic run_burst(input int d, input int n, input bit cp, input bit ch,
                           input int ka_in, input bit hold, input bit noise,
                           input int stop_after);
    int   pp, per, q, h, len, ka, jmax, nl, ns, nsck, k, m, phk;
    logic e_busy, e_done, e_l, e_s, e_sck, prev_o, sup;
    pp  = (d < 3) ? 3 : d;
    per = pp + 1;
    q   = per >> 2;
    h   = per >> 1;
    ka  = (n == 0 || ka_in > n * per) ? 0 : ka_in;
    len = (ka != 0) ? ka : n * per;
    div   = 8'(d);
    num   = 8'(n);
    cpol  = cp;
    cpha  = ch;
    start = 1'b1;
    abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    jmax   = (stop_after > 0) ? stop_after : len + DLY + 4;
    nl     = 0;
    ns     = 0;
    nsck   = 0;
    prev_o = prev_cpol;
    for (int j = 1; j <= jmax; j++) begin
      if (j == ka) abort = 1'b1;
      else if (noise && j == len + 1) abort = 1'($urandom_range(0, 1));
      else abort = 1'b0;
      if (hold && j == len + 1) start = 1'b0;
      @(negedge clk);
      e_busy = (j >= 1) && (j <= len + 1);
      e_done = (j == len + 2);
      k   = j - 1;
      phk = phase(k, per);
      sup = (ka != 0) && (k >= ka);
      e_l = run_at(k, len) && !sup && (ch ? (phk == q) : (phk == 0));
      e_s = run_at(k, len) && !sup && (ch ? (phk == q + h) : (phk == q));
      m = j - DLY;
      if (m <= 0) begin
        e_sck = prev_cpol;
      end else begin
        phk   = phase(m - 1, per);
        e_sck = cp ^ (run_at(m - 1, len) && phk >= q && phk < q + h);
      end
      chk("busy", j, busy, e_busy);
      chk("done", j, done, e_done);
      chk("launch_req", j, launch_req, e_l);
      chk("sample_req", j, sample_req, e_s);
      chk("sck_o", j, sck_o, e_sck);
      if (launch_req === 1'b1) nl++;
      if (sample_req === 1'b1) ns++;
      if (prev_o === cp && sck_o === ~cp) nsck++;
      prev_o = sck_o;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    if (stop_after == 0) begin
      if (ka == 0) begin
        chk_cnt("launch_count", nl, n);
        chk_cnt("sample_count", ns, n);
        chk_cnt("sck_pulse_count", nsck, n);
      end
      prev_cpol = cp;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    div   = '0;
    num   = '0;
    cpol  = 1'b0;
    cpha  = 1'b0;
    prev_cpol = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 0, busy, 1'b0);
    chk("rst_done", 0, done, 1'b0);
    chk("rst_launch", 0, launch_req, 1'b0);
    chk("rst_sample", 0, sample_req, 1'b0);
    chk("rst_sck", 0, sck_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios.
    run_burst(7, 3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    run_burst(7, 3, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0);
    run_burst(7, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    run_burst(7, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
    run_burst(1, 2, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
    run_burst(0, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    run_burst(7, 5, 1'b0, 1'b0, 11, 1'b0, 1'b0, 0);
    run_burst(9, 5, 1'b1, 1'b1, 14, 1'b0, 1'b0, 0);
    run_burst(255, 1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0);

    // Reset mid-burst with start held high throughout.
    run_burst(7, 4, 1'b1, 1'b0, 0, 1'b1, 1'b0, 12);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy", 0, busy, 1'b0);
    chk("midrst_done", 0, done, 1'b0);
    chk("midrst_launch", 0, launch_req, 1'b0);
    chk("midrst_sample", 0, sample_req, 1'b0);
    chk("midrst_sck", 0, sck_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_done2", 1, done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    prev_cpol = 1'b0;
    run_burst(5, 2, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0);

    // Randomized bursts with optional abort, held start and ignored-abort noise.
    for (int i = 0; i < 40; i++) begin
      int  d, n, per, ka;
      bit  cp, ch, hold;
      d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 12));
      n  = (d > 20) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 5));
      cp   = 1'($urandom_range(0, 1));
      ch   = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      per  = ((d < 3) ? 3 : d) + 1;
      ka   = 0;
      if (n > 0 && $urandom_range(0, 3) == 0) ka = int'($urandom_range(1, n * per));
      run_burst(d, n, cp, ch, ka, hold, 1'b1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
